ball_motion_controller: RTL and testbench

- Per-frame scheduler that drives the position and enable inputs of the ball spot generator.
- Integrates ball velocity once per frame and detects coincidence between the ball and the two player spots during active video.
- Applies rebound, "English" (vertical steering) and wall reflection; removes and re-serves the ball after a miss.
- Sits between the video timing block, the player spot generators and the ball spot generator.

---
 rtl/ball_motion_pkg.sv | 30 +++
 rtl/ball_axis_integrator.sv | 43 ++++
 rtl/ball_motion_controller.sv | 186 ++++++++++++++++++
 tb/tb_ball_motion_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ball_motion_pkg.sv
// Shared constants for the ball motion slice: FSM encoding, directions
// and the playfield limits also used by the player and wall controllers.
package ball_motion_pkg;

   typedef enum logic [1:0] {
      ST_SERVE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_MISS  = 2'd2
   } state_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam int H_BITWIDTH_DEF   = 9;
   localparam int V_BITWIDTH_DEF   = 9;
   localparam int H_MIN_DEF        = 16;
   localparam int H_MAX_DEF        = 240;
   localparam int V_MIN_DEF        = 8;
   localparam int V_MAX_DEF        = 232;
   localparam int BALL_HEIGHT_DEF  = 4;
   localparam int H_CENTER_DEF     = 128;
   localparam int V_CENTER_DEF     = 120;
   localparam int SERVE_FRAMES_DEF = 60;

   // Zero speed would stall the ball forever; treat it as one pixel.
   function automatic logic [2:0] eff_speed(input logic [2:0] s);
      return (s == 3'd0) ? 3'd1 : s;
   endfunction

endpackage

// File: rtl/ball_axis_integrator.sv
// One axis of ball motion: pos + signed step, limit flags, optional clamp.
// Ports: pos/step in, pos_next out, below/above flag the crossed limit.
module ball_axis_integrator #(
   parameter int W     = 9,
   parameter int LO    = 0,
   parameter int HI    = 255,
   parameter bit CLAMP = 1'b1
) (
   input  logic [W-1:0]        pos,
   input  logic signed [W:0]   step,
   output logic [W-1:0]        pos_next,
   output logic                below,
   output logic                above
);

   // Two guard bits so neither underflow nor overflow can wrap.
   localparam int SW = W + 2;
   localparam logic signed [SW-1:0] LO_S = SW'(LO);
   localparam logic signed [SW-1:0] HI_S = SW'(HI);
   localparam logic [W-1:0] LO_U = W'(LO);
   localparam logic [W-1:0] HI_U = W'(HI);

   logic signed [SW-1:0] pos_s;
   logic signed [SW-1:0] step_s;
   logic signed [SW-1:0] sum;

   assign pos_s  = {2'b00, pos};
   assign step_s = {step[W], step};
   assign sum    = pos_s + step_s;
   assign below  = sum < LO_S;
   assign above  = sum > HI_S;

   always_comb begin
      pos_next = sum[W-1:0];
      if (CLAMP) begin
         if (below)
            pos_next = LO_U;
         else if (above)
            pos_next = HI_U;
      end
   end

endmodule

// File: rtl/ball_motion_controller.sv
// Per-frame ball scheduler: serve delay, motion, rebound, walls, misses.
// Ports: clk/reset, frame_start, pixel hits, speed/english in; ball pos/enable, miss pulses, state out.
module ball_motion_controller
   import ball_motion_pkg::*;
#(
   parameter int h_bitwidth   = H_BITWIDTH_DEF,
   parameter int v_bitwidth   = V_BITWIDTH_DEF,
   parameter int H_MIN        = H_MIN_DEF,
   parameter int H_MAX        = H_MAX_DEF,
   parameter int V_MIN        = V_MIN_DEF,
   parameter int V_MAX        = V_MAX_DEF,
   parameter int BALL_HEIGHT  = BALL_HEIGHT_DEF,
   parameter int H_CENTER     = H_CENTER_DEF,
   parameter int V_CENTER     = V_CENTER_DEF,
   parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  ball_pix,
   input  logic                  p1_pix,
   input  logic                  p2_pix,
   input  logic [2:0]            h_speed,
   input  logic [3:0]            english,
   input  logic                  serve_req,
   output logic [h_bitwidth-1:0] ball_h_pos,
   output logic [v_bitwidth-1:0] ball_v_pos,
   output logic                  ball_enable,
   output logic                  miss_p1,
   output logic                  miss_p2,
   output logic [1:0]            state_dbg
);

   localparam int CW = $clog2(SERVE_FRAMES + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(SERVE_FRAMES);
   localparam logic [h_bitwidth-1:0] H_C = h_bitwidth'(H_CENTER);
   localparam logic [v_bitwidth-1:0] V_C = v_bitwidth'(V_CENTER);

   state_e state, state_nxt;

   logic                        h_dir;
   logic signed [v_bitwidth:0]  v_vel;
   logic [CW-1:0]               cnt;
   logic                        hit1, hit2;
   logic                        missed_left;

   logic                        hit_any;
   logic                        eff_dir;
   logic signed [v_bitwidth:0]  eff_vel;
   logic signed [v_bitwidth:0]  eng_ext;
   logic signed [h_bitwidth:0]  spd_s;
   logic signed [h_bitwidth:0]  h_step;
   logic [h_bitwidth-1:0]       h_next;
   logic [v_bitwidth-1:0]       v_next;
   logic                        h_below, h_above;
   logic                        v_below, v_above;

   // A rebound latched during the frame takes effect before the move.
   assign hit_any = hit1 | hit2;
   assign eng_ext = {{(v_bitwidth-3){english[3]}}, english};
   assign eff_dir = hit_any ? ~h_dir : h_dir;
   assign eff_vel = hit_any ? eng_ext : v_vel;
   assign spd_s   = (h_bitwidth+1)'(eff_speed(h_speed));
   assign h_step  = (eff_dir == DIR_RIGHT) ? spd_s : -spd_s;

   ball_axis_integrator #(
      .W     (h_bitwidth),
      .LO    (H_MIN),
      .HI    (H_MAX),
      .CLAMP (1'b0)
   ) u_h_axis (
      .pos      (ball_h_pos),
      .step     (h_step),
      .pos_next (h_next),
      .below    (h_below),
      .above    (h_above)
   );

   ball_axis_integrator #(
      .W     (v_bitwidth),
      .LO    (V_MIN),
      .HI    (V_MAX - BALL_HEIGHT),
      .CLAMP (1'b1)
   ) u_v_axis (
      .pos      (ball_v_pos),
      .step     (eff_vel),
      .pos_next (v_next),
      .below    (v_below),
      .above    (v_above)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_SERVE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (frame_start) begin
         unique case (state)
            ST_SERVE:
               if (!serve_req && cnt <= CW'(1))
                  state_nxt = ST_PLAY;
            ST_PLAY:
               if (serve_req)
                  state_nxt = ST_SERVE;
               else if (h_below || h_above)
                  state_nxt = ST_MISS;
            ST_MISS:
               state_nxt = ST_SERVE;
            default:
               state_nxt = ST_SERVE;
         endcase
      end
   end

   always_comb begin
      ball_enable = (state == ST_PLAY);
      state_dbg   = state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ball_h_pos  <= H_C;
         ball_v_pos  <= V_C;
         h_dir       <= DIR_RIGHT;
         v_vel       <= '0;
         cnt         <= CNT_INIT;
         hit1        <= 1'b0;
         hit2        <= 1'b0;
         missed_left <= 1'b0;
         miss_p1     <= 1'b0;
         miss_p2     <= 1'b0;
      end else begin
         miss_p1 <= 1'b0;
         miss_p2 <= 1'b0;
         // Only hits against the current direction count.
         if (state == ST_PLAY && !frame_start) begin
            if (ball_pix && p1_pix && h_dir == DIR_LEFT)
               hit1 <= 1'b1;
            if (ball_pix && p2_pix && h_dir == DIR_RIGHT)
               hit2 <= 1'b1;
         end
         if (frame_start) begin
            unique case (state)
               ST_SERVE: begin
                  if (serve_req)
                     cnt <= CNT_INIT;
                  else if (cnt != '0)
                     cnt <= cnt - CW'(1);
               end
               ST_PLAY: begin
                  hit1 <= 1'b0;
                  hit2 <= 1'b0;
                  if (serve_req) begin
                     ball_h_pos <= H_C;
                     ball_v_pos <= V_C;
                     v_vel      <= '0;
                     cnt        <= CNT_INIT;
                  end else begin
                     h_dir      <= eff_dir;
                     ball_h_pos <= h_next;
                     ball_v_pos <= v_next;
                     v_vel      <= (v_below || v_above) ? -eff_vel : eff_vel;
                     miss_p1    <= h_below;
                     miss_p2    <= h_above && !h_below;
                     if (h_below || h_above)
                        missed_left <= h_below;
                  end
               end
               ST_MISS: begin
                  ball_h_pos <= H_C;
                  ball_v_pos <= V_C;
                  v_vel      <= '0;
                  cnt        <= CNT_INIT;
                  h_dir      <= missed_left ? DIR_LEFT : DIR_RIGHT;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_motion_controller.sv
// Directed bench for ball_motion_controller with hand-computed vectors.
// Drives frames, overlaps, misses and resets; checks outputs at negedge.
module tb_ball_motion_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_start;
   logic       ball_pix, p1_pix, p2_pix;
   logic [2:0] h_speed;
   logic [3:0] english;
   logic       serve_req;
   logic [8:0] ball_h_pos;
   logic [8:0] ball_v_pos;
   logic       ball_enable;
   logic       miss_p1, miss_p2;
   logic [1:0] state_dbg;

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   ball_motion_controller dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .ball_pix    (ball_pix),
      .p1_pix      (p1_pix),
      .p2_pix      (p2_pix),
      .h_speed     (h_speed),
      .english     (english),
      .serve_req   (serve_req),
      .ball_h_pos  (ball_h_pos),
      .ball_v_pos  (ball_v_pos),
      .ball_enable (ball_enable),
      .miss_p1     (miss_p1),
      .miss_p2     (miss_p2),
      .state_dbg   (state_dbg)
   );

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic frame();
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++)
         frame();
   endtask

   task automatic overlap(input logic p1, input logic p2);
      @(negedge clk) begin
         ball_pix = 1'b1; p1_pix = p1; p2_pix = p2;
      end
      @(negedge clk);
      @(negedge clk) begin
         ball_pix = 1'b0; p1_pix = 1'b0; p2_pix = 1'b0;
      end
   endtask

   task automatic pos(input string tag, input int h, input int v);
      chk({tag, "_h"}, ball_h_pos, h);
      chk({tag, "_v"}, ball_v_pos, v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; frame_start = 1'b0;
      ball_pix = 1'b0; p1_pix = 1'b0; p2_pix = 1'b0;
      h_speed = 3'd3; english = 4'd0; serve_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      pos("rst", 128, 120);
      chk("rst_en", ball_enable, 0);
      chk("rst_st", state_dbg, 0);
      chk("rst_m1", miss_p1, 0);
      chk("rst_m2", miss_p2, 0);

      frames(59);
      chk("srv59_en", ball_enable, 0);
      chk("srv59_st", state_dbg, 0);
      frame();
      chk("srv60_en", ball_enable, 1);
      chk("srv60_st", state_dbg, 1);
      pos("srv60", 128, 120);

      frames(5);
      pos("run5", 143, 120);
      chk("run5_en", ball_enable, 1);

      english = 4'hE;
      overlap(1'b0, 1'b1);
      frame();
      pos("hit2", 140, 118);

      english = 4'd5;
      overlap(1'b0, 1'b1);
      frame();
      pos("p2_left_ign", 137, 116);
      frame();
      pos("plain", 134, 114);

      english = 4'hC;
      overlap(1'b1, 1'b0);
      frame();
      pos("hit1", 137, 110);

      english = 4'd7;
      overlap(1'b1, 1'b0);
      frame();
      pos("p1_right_ign", 140, 106);

      frames(24);
      pos("pre_wall", 212, 10);
      frame();
      pos("wall", 215, 8);
      frame();
      pos("wall_refl", 218, 12);

      english = 4'd0; h_speed = 3'd2;
      overlap(1'b0, 1'b1);
      frame();
      pos("hit2_spd2", 216, 12);

      h_speed = 3'd3;
      frames(66);
      pos("pre_miss", 18, 12);
      chk("pre_miss_st", state_dbg, 1);
      frame();
      chk("miss_m1", miss_p1, 1);
      chk("miss_m2", miss_p2, 0);
      chk("miss_en", ball_enable, 0);
      chk("miss_st", state_dbg, 2);
      @(negedge clk);
      chk("miss_m1_pulse", miss_p1, 0);
      frame();
      chk("reserve_st", state_dbg, 0);
      pos("reserve", 128, 120);
      chk("reserve_en", ball_enable, 0);

      frames(60);
      chk("srv2_en", ball_enable, 1);
      frame();
      pos("dir_left", 125, 120);

      @(negedge clk) begin
         ball_pix = 1'b1; p1_pix = 1'b1;
      end
      @(negedge clk) reset = 1'b1;
      @(negedge clk) begin
         ball_pix = 1'b0; p1_pix = 1'b0;
      end
      pos("rst2", 128, 120);
      chk("rst2_en", ball_enable, 0);
      chk("rst2_st", state_dbg, 0);
      chk("rst2_m1", miss_p1, 0);
      reset = 1'b0;
      frames(60);
      chk("srv3_en", ball_enable, 1);
      frame();
      pos("no_rebound", 131, 120);

      h_speed = 3'd0;
      frame();
      pos("spd0", 132, 120);

      serve_req = 1'b1;
      frame();
      serve_req = 1'b0;
      chk("sreq_st", state_dbg, 0);
      pos("sreq", 128, 120);
      chk("sreq_m1", miss_p1, 0);
      chk("sreq_m2", miss_p2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
